// File: rtl/echo_remover.sv
// echo_remover: strips a single delayed, attenuated echo from a strobed
// unsigned sample stream. It rebuilds the dry signal from its own recovered
// history, held in a DEPTH-entry circular buffer.
module echo_remover #(
  parameter int RESOLUTION = 32,
  parameter int DEPTH      = 128,
  parameter int SHIFT      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [RESOLUTION-1:0] data_in,
  output logic                  out_valid,
  output logic [RESOLUTION-1:0] data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Unsigned echo term: logical right shift of a stored recovered sample.
  function automatic logic [RESOLUTION-1:0] echo_term(input logic [RESOLUTION-1:0] x);
    return x >> SHIFT;
  endfunction

  // Modular subtraction. Underflow wraps so that encode/decode round-trips exactly.
  function automatic logic [RESOLUTION-1:0] wrap_sub(input logic [RESOLUTION-1:0] a,
                                                     input logic [RESOLUTION-1:0] b);
    return a - b;
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_fill_cnt;
  logic [RESOLUTION-1:0]  r_buf [DEPTH];

  logic [RESOLUTION-1:0]  w_tap_p0;
  logic [RESOLUTION-1:0]  w_d_p0;
  logic [RESOLUTION-1:0]  w_result_p0;
  logic                   w_accept_p0;

  logic                   r_vld_p1;
  logic [RESOLUTION-1:0]  r_data_p1;

  // ---- stage p0: input sample, delayed-term lookup and recovery ----
  assign w_accept_p0 = in_valid;

  // Oldest entry sits at the write pointer. It is read here before this
  // edge overwrites it.
  assign w_tap_p0 = r_buf[r_wr_ptr];

  // State register: FILL until DEPTH samples are accepted, then RUN until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave FILL on the edge that accepts the DEPTH-th sample.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == FILL && w_accept_p0 && r_fill_cnt == FILL_LAST) begin
      w_state_nxt = RUN;
    end
  end

  // State outputs: the delayed term is masked while the history is still unwritten.
  always_comb begin
    w_d_p0 = '0;
    if (r_state == RUN) begin
      w_d_p0 = echo_term(w_tap_p0);
    end
  end

  // Echo removal when enabled, plain pass-through in bypass.
  always_comb begin
    w_result_p0 = data_in;
    if (enable) begin
      w_result_p0 = wrap_sub(data_in, w_d_p0);
    end
  end

  // Fill counter: counts accepted samples only while in FILL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fill_cnt <= '0;
    end else if (r_state == FILL && w_accept_p0) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  // Write pointer: advances per accepted sample and wraps naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if (w_accept_p0) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // History store: the recovered (or bypassed) sample replaces the oldest entry.
  // It has no reset because FILL masks stale contents.
  always_ff @(posedge clk) begin
    if (w_accept_p0 && !reset) begin
      r_buf[r_wr_ptr] <= w_result_p0;
    end
  end

  // ---- stage p1: registered output, one clock after the strobe ----
  // Valid pulse for each accepted sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept_p0;
    end
  end

  // Output sample register: updated on accepted samples and held across gaps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_p1 <= '0;
    end else if (w_accept_p0) begin
      r_data_p1 <= w_result_p0;
    end
  end

  assign out_valid = r_vld_p1;
  assign data_out  = r_data_p1;

endmodule

// File: tb/tb_echo_remover.sv
// Scoreboard bench for echo_remover with DEPTH=4, SHIFT=4, RESOLUTION=32.
// The driver pushes each expected output with the cycle it must appear on.
// The monitor pops and compares whenever out_valid is seen.
module tb_echo_remover;

  localparam int RES = 32;
  localparam int DEP = 4;
  localparam int SH  = 4;

  logic           clk;
  logic           reset;
  logic           enable;
  logic           in_valid;
  logic [RES-1:0] data_in;
  logic           out_valid;
  logic [RES-1:0] data_out;

  echo_remover #(.RESOLUTION(RES), .DEPTH(DEP), .SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .data_in(data_in), .out_valid(out_valid), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RES-1:0] v;
    int             due;
    string          name;
  } exp_t;

  exp_t           sb[$];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;

  // Reference decoder history: every output produced since the last reset.
  logic [RES-1:0] ref_hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks each out_valid against the queue head and reports missing or extra outputs.
  always @(negedge clk) begin
    if (out_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got out_valid=1 data_out=%h, required no output", data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (data_out !== e.v || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s: got data_out=%h at cycle %0d, required %h at cycle %0d",
                   e.name, data_out, cyc, e.v, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: got out_valid=0 at cycle %0d, required %h", e.name, cyc, e.v);
    end
  end

  // Drives one sample for one cycle and queues its expected output.
  task automatic send(input logic [RES-1:0] d, input logic en,
                      input logic [RES-1:0] exp_v, input string nm);
    exp_t e;
    in_valid = 1'b1;
    data_in  = d;
    enable   = en;
    e.v = exp_v; e.due = cyc + 1; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = $urandom;
  endtask

  // Idle cycles. enable is scrambled to show that it is ignored without in_valid.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      enable = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Behavioural decoder: x[n] = e[n] - (x[n-DEPTH] >> SHIFT), with zero history before DEPTH samples.
  task automatic send_model(input logic [RES-1:0] d, input logic en, input string nm);
    logic [RES-1:0] dl, r;
    int n;
    n  = ref_hist.size();
    dl = (n >= DEP) ? (ref_hist[n-DEP] >> SH) : '0;
    r  = en ? d - dl : d;
    ref_hist.push_back(r);
    send(d, en, r, nm);
  endtask

  task automatic check_val(input string nm, input logic [RES-1:0] got, input logic [RES-1:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  // Asynchronous reset pulse, asserted mid-cycle. Anything still queued is in flight and is dropped.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    ref_hist.delete();
    #1;
    check_val("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("reset_data_out", data_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outputs pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  logic [RES-1:0] echo_in [9]  = '{32'd160, 0, 0, 0, 32'd10, 0, 0, 0, 0};
  logic [RES-1:0] echo_out[9]  = '{32'd160, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [RES-1:0] uf_in   [9]  = '{32'd160, 0, 0, 0, 32'd5, 0, 0, 0, 32'h1000_0000};
  logic [RES-1:0] uf_out  [9]  = '{32'd160, 0, 0, 0, 32'hFFFF_FFFB, 0, 0, 0, 32'h0000_0001};

  initial begin
    logic [RES-1:0] xs[$];
    logic [RES-1:0] x, e;
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    #2;
    check_val("por_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("por_data_out", data_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fill pass-through
    for (int i = 1; i <= 4; i++) send(RES'(i), 1'b1, RES'(i), "fill_pass");
    drain();

    // Echo removal, back to back
    do_reset();
    for (int i = 0; i < 9; i++) send(echo_in[i], 1'b1, echo_out[i], "echo_remove");
    drain();
    check_val("hold_after_stream", data_out, 32'd0);

    // Underflow wrap and reuse of the wrapped value DEPTH samples later
    do_reset();
    for (int i = 0; i < 9; i++) send(uf_in[i], 1'b1, uf_out[i], "underflow_wrap");
    drain();

    // Echo removal with 3-cycle gaps (the monitor flags any valid seen in a gap)
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(echo_in[i], 1'b1, echo_out[i], "echo_gaps");
      idle(3);
    end
    drain();

    // Bypass writes history; re-enabling then uses the bypassed samples
    do_reset();
    send(32'd160, 1'b0, 32'd160, "bypass");
    send(32'd0,   1'b0, 32'd0,   "bypass");
    send(32'd0,   1'b0, 32'd0,   "bypass");
    send(32'd0,   1'b0, 32'd0,   "bypass");
    send(32'd170, 1'b0, 32'd170, "bypass");
    send(32'd0,   1'b1, 32'd0,   "bypass_then_enable");
    send(32'd0,   1'b1, 32'd0,   "bypass_then_enable");
    send(32'd0,   1'b1, 32'd0,   "bypass_then_enable");
    send(32'd20,  1'b1, 32'd10,  "bypass_then_enable");
    drain();

    // Reset mid-stream: the 6th sample is dropped and the next 4 pass through in FILL
    do_reset();
    for (int i = 0; i < 5; i++) send(echo_in[i], 1'b1, echo_out[i], "pre_reset");
    in_valid = 1'b1; data_in = 32'd99; enable = 1'b1;
    #3;
    do_reset();
    for (int i = 7; i <= 10; i++) send(RES'(i), 1'b1, RES'(i), "post_reset_fill");
    send(32'd160, 1'b1, 32'd160, "post_reset_run");
    drain();

    // Random round trip: encode x with zero initial history, then decode, expecting x back
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      x = $urandom;
      e = x + ((n >= DEP) ? (xs[n-DEP] >> SH) : '0);
      xs.push_back(x);
      send(e, 1'b1, x, "round_trip");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Random stream with random enable against the behavioural decoder
    do_reset();
    for (int n = 0; n < 300; n++) begin
      send_model($urandom, 1'($urandom), "random_enable");
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
